// File: rtl/spi_xfer_arb_if.sv
// Wishbone master bundle between spi_xfer_arb and the wb_spi register window.
interface spi_xfer_arb_if;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic [31:0] m_dat_i;
  logic [3:0]  m_sel_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic        m_ack_i;

  modport master (
    output m_adr_o, m_dat_o, m_sel_o, m_cyc_o, m_stb_o, m_we_o,
    input  m_dat_i, m_ack_i
  );

  modport slave (
    input  m_adr_o, m_dat_o, m_sel_o, m_cyc_o, m_stb_o, m_we_o,
    output m_dat_i, m_ack_i
  );
endinterface

// File: rtl/spi_xfer_arb.sv
// Two-client round-robin session arbiter that sequences wb_spi register accesses per byte.
// Chip select is held low for the whole of a granted session.
module spi_xfer_arb #(
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter logic [7:0]  DIVISOR  = 8'h03
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       c0_req,
  input  logic       c1_req,
  output logic       c0_gnt,
  output logic       c1_gnt,
  input  logic       c0_stb,
  input  logic       c1_stb,
  input  logic [7:0] c0_tx,
  input  logic [7:0] c1_tx,
  output logic [7:0] c0_rx,
  output logic [7:0] c1_rx,
  output logic       c0_done,
  output logic       c1_done,
  spi_xfer_arb_if.master m
);

  typedef enum logic [3:0] {
    StInitDiv, StInitCs, StIdle, StCsOn, StWaitByte, StWrData, StPoll, StRdData, StCsOff
  } state_e;

  state_e          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      done_q, done_d;
  logic [1:0][7:0] rx_q, rx_d;
  logic [7:0]      tx_q, tx_d;

  logic       ack;
  logic       req_own;
  logic       stb_own;
  logic [7:0] tx_own;
  logic       acc_next;
  logic       unused_dat;

  assign ack        = cyc_q & m.m_ack_i;
  assign req_own    = owner_q ? c1_req : c0_req;
  assign stb_own    = owner_q ? c1_stb : c0_stb;
  assign tx_own     = owner_q ? c1_tx : c0_tx;
  assign unused_dat = ^m.m_dat_i[31:8];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    rx_d    = rx_q;
    tx_d    = tx_q;
    unique case (state_q)
      StInitDiv: if (ack) state_d = StInitCs;
      StInitCs:  if (ack) state_d = StIdle;
      StIdle: begin
        if (c0_req || c1_req) begin
          // On a tie the client not granted last wins.
          owner_d = (c0_req && c1_req) ? ~last_q : c1_req;
          last_d  = owner_d;
          state_d = StCsOn;
        end
      end
      StCsOn: begin
        if (ack) begin
          gnt_d[owner_q] = 1'b1;
          state_d        = StWaitByte;
        end
      end
      StWaitByte: begin
        // A strobe beats a simultaneous req drop: the byte runs first.
        if (stb_own) begin
          tx_d    = tx_own;
          state_d = StWrData;
        end else if (!req_own) begin
          gnt_d   = '0;
          state_d = StCsOff;
        end
      end
      StWrData: if (ack) state_d = StPoll;
      StPoll:   if (ack && !m.m_dat_i[0]) state_d = StRdData;
      StRdData: begin
        if (ack) begin
          rx_d[owner_q]   = m.m_dat_i[7:0];
          done_d[owner_q] = 1'b1;
          state_d         = StWaitByte;
        end
      end
      StCsOff:  if (ack) state_d = StIdle;
      default:  state_d = StInitDiv;
    endcase
  end

  // An ack always closes the cycle, giving one idle cycle before the next access.
  assign acc_next = (state_d != StIdle) && (state_d != StWaitByte);
  assign cyc_d    = ack ? 1'b0 : acc_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StInitDiv;
      cyc_q   <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= '0;
      done_q  <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
    end
  end

  logic [31:0] adr;
  logic [31:0] dat;
  logic        we;

  always_comb begin
    adr = '0;
    dat = '0;
    we  = 1'b0;
    if (cyc_q) begin
      case (state_q)
        StInitDiv: begin adr = BASE_ADR + 32'h10; dat = {24'h0, DIVISOR}; we = 1'b1; end
        StInitCs,
        StCsOff:   begin adr = BASE_ADR + 32'h08; dat = 32'h1; we = 1'b1; end
        StCsOn:    begin adr = BASE_ADR + 32'h08; dat = 32'h0; we = 1'b1; end
        StWrData:  begin adr = BASE_ADR;          dat = {24'h0, tx_q}; we = 1'b1; end
        StPoll:    adr = BASE_ADR + 32'h04;
        StRdData:  adr = BASE_ADR;
        default:   adr = '0;
      endcase
    end
  end

  assign m.m_adr_o = adr;
  assign m.m_dat_o = dat;
  assign m.m_we_o  = we;
  assign m.m_cyc_o = cyc_q;
  assign m.m_stb_o = cyc_q;
  assign m.m_sel_o = 4'hF;

  assign c0_gnt  = gnt_q[0];
  assign c1_gnt  = gnt_q[1];
  assign c0_done = done_q[0];
  assign c1_done = done_q[1];
  assign c0_rx   = rx_q[0];
  assign c1_rx   = rx_q[1];

endmodule

// File: tb/tb_spi_xfer_arb.sv
// Scoreboard bench: stimulus pushes expected bus/grant/done events, a negedge monitor pops them.
module tb_spi_xfer_arb;
  localparam logic [31:0] Base  = 32'h4000_0100;
  localparam logic [31:0] AData = Base;
  localparam logic [31:0] AStat = Base + 32'h04;
  localparam logic [31:0] ACs   = Base + 32'h08;
  localparam logic [31:0] ADiv  = Base + 32'h10;
  localparam logic [1:0]  KWr = 2'd0, KRd = 2'd1, KGnt = 2'd2, KDone = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       c0_req, c1_req, c0_stb, c1_stb;
  logic [7:0] c0_tx, c1_tx, c0_rx, c1_rx;
  logic       c0_gnt, c1_gnt, c0_done, c1_done;

  spi_xfer_arb_if bus ();

  spi_xfer_arb #(.BASE_ADR(Base), .DIVISOR(8'h03)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .c0_req  (c0_req),
    .c1_req  (c1_req),
    .c0_gnt  (c0_gnt),
    .c1_gnt  (c1_gnt),
    .c0_stb  (c0_stb),
    .c1_stb  (c1_stb),
    .c0_tx   (c0_tx),
    .c1_tx   (c1_tx),
    .c0_rx   (c0_rx),
    .c1_rx   (c1_rx),
    .c0_done (c0_done),
    .c1_done (c1_done),
    .m       (bus)
  );

  always #5 clk = ~clk;

  // Slave: acks one cycle after stb; DATA loops back; run stays high for two polls.
  logic       s_ack;
  logic [7:0] s_data;
  int         s_busy;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_ack  <= 1'b0;
      s_busy <= 0;
      s_data <= 8'h00;
    end else begin
      s_ack <= bus.m_cyc_o && bus.m_stb_o && !s_ack;
      if (bus.m_cyc_o && bus.m_stb_o && s_ack) begin
        if (bus.m_we_o && bus.m_adr_o == AData) begin
          s_data <= bus.m_dat_o[7:0];
          s_busy <= 2;
        end
        if (!bus.m_we_o && bus.m_adr_o == AStat && s_busy > 0) s_busy <= s_busy - 1;
      end
    end
  end
  assign bus.m_ack_i = s_ack;
  assign bus.m_dat_i = (bus.m_adr_o == AStat) ? {31'h0, s_busy != 0} :
                       (bus.m_adr_o == AData) ? {24'h0, s_data} : 32'h0;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  function automatic void push(input logic [1:0] k, input logic [31:0] aa, input logic [31:0] dd);
    exp_q.push_back(ev_t'{kind: k, a: aa, d: dd});
  endfunction

  task automatic got(input logic [1:0] k, input logic [31:0] aa, input logic [31:0] dd);
    ev_t x;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected event: got kind %0d a %h d %h, want none", k, aa, dd);
    end else begin
      x = exp_q.pop_front();
      check("event kind", {30'h0, k}, {30'h0, x.kind});
      check("event addr/client", aa, x.a);
      check("event data", dd, x.d);
    end
  endtask

  logic [1:0] gnt_prev  = 2'b00;
  logic [1:0] done_prev = 2'b00;
  always @(negedge clk) begin
    if (bus.m_cyc_o && bus.m_stb_o && bus.m_ack_i) begin
      if (bus.m_we_o) got(KWr, bus.m_adr_o, bus.m_dat_o);
      else            got(KRd, bus.m_adr_o, bus.m_dat_i);
    end
    if (c0_gnt !== gnt_prev[0]) got(KGnt, 32'd0, {31'h0, c0_gnt});
    if (c1_gnt !== gnt_prev[1]) got(KGnt, 32'd1, {31'h0, c1_gnt});
    if (c0_done === 1'b1) begin
      check("c0_done width", {31'h0, done_prev[0]}, 32'h0);
      got(KDone, 32'd0, {24'h0, c0_rx});
    end
    if (c1_done === 1'b1) begin
      check("c1_done width", {31'h0, done_prev[1]}, 32'h0);
      got(KDone, 32'd1, {24'h0, c1_rx});
    end
    gnt_prev  <= {c1_gnt, c0_gnt};
    done_prev <= {c1_done, c0_done};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic probe(input int w);
    case (w)
      0: return c0_gnt;
      1: return c1_gnt;
      2: return c0_done;
      3: return c1_done;
      4: return bus.m_cyc_o && !bus.m_we_o && bus.m_adr_o == AStat;
      5: return bus.m_cyc_o && bus.m_we_o && bus.m_adr_o == AData;
      default: return exp_q.size() == 0;
    endcase
  endfunction

  task automatic wait_for(input string name, input int w, input logic lvl);
    int n = 0;
    while (probe(w) !== lvl && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout %s: got no event in %0d cycles, want level %0b", name, n, lvl);
    end
  endtask

  task automatic push_byte(input logic [31:0] cl, input logic [7:0] b);
    push(KWr, AData, {24'h0, b});
    push(KRd, AStat, 32'h1);
    push(KRd, AStat, 32'h1);
    push(KRd, AStat, 32'h0);
    push(KRd, AData, {24'h0, b});
    push(KDone, cl, {24'h0, b});
  endtask

  initial begin
    reset_n = 1'b0;
    c0_req = 1'b0; c1_req = 1'b0; c0_stb = 1'b0; c1_stb = 1'b0;
    c0_tx = 8'h00; c1_tx = 8'h00;
    repeat (2) tick();
    check("reset m_cyc_o", {31'h0, bus.m_cyc_o}, 32'h0);
    check("reset m_stb_o", {31'h0, bus.m_stb_o}, 32'h0);
    check("reset m_we_o", {31'h0, bus.m_we_o}, 32'h0);
    check("reset m_adr_o", bus.m_adr_o, 32'h0);
    check("reset m_dat_o", bus.m_dat_o, 32'h0);
    check("reset m_sel_o", {28'h0, bus.m_sel_o}, 32'hF);
    check("reset c0_gnt", {31'h0, c0_gnt}, 32'h0);
    check("reset c1_gnt", {31'h0, c1_gnt}, 32'h0);
    check("reset c0_done", {31'h0, c0_done}, 32'h0);
    check("reset c1_done", {31'h0, c1_done}, 32'h0);
    check("reset c0_rx", {24'h0, c0_rx}, 32'h0);
    check("reset c1_rx", {24'h0, c1_rx}, 32'h0);

    // Both clients request from reset: init first, then client 0 wins the tie.
    push(KWr, ADiv, 32'h3);
    push(KWr, ACs, 32'h1);
    push(KWr, ACs, 32'h0);
    push(KGnt, 32'd0, 32'h1);
    c0_req = 1'b1; c1_req = 1'b1;
    tick();
    reset_n = 1'b1;
    wait_for("c0_gnt rise", 0, 1'b1);

    c1_tx = 8'h11; c1_stb = 1'b1; tick(); c1_stb = 1'b0; tick();
    push_byte(32'd0, 8'hA5);
    c0_tx = 8'hA5; c0_stb = 1'b1; tick(); c0_stb = 1'b0;
    wait_for("c0 poll", 4, 1'b1);
    c0_tx = 8'hFF; c0_stb = 1'b1; tick(); c0_stb = 1'b0;
    wait_for("c0_done A5", 2, 1'b1);

    // Strobe in the done cycle is accepted.
    push_byte(32'd0, 8'h3C);
    c0_tx = 8'h3C; c0_stb = 1'b1; tick(); c0_stb = 1'b0;
    wait_for("c0_done 3C", 2, 1'b1);

    push(KGnt, 32'd0, 32'h0);
    push(KWr, ACs, 32'h1);
    push(KWr, ACs, 32'h0);
    push(KGnt, 32'd1, 32'h1);
    c0_req = 1'b0;
    wait_for("c1_gnt rise", 1, 1'b1);

    push_byte(32'd1, 8'h5A);
    c1_tx = 8'h5A; c1_stb = 1'b1; tick(); c1_stb = 1'b0;
    wait_for("c1_done 5A", 3, 1'b1);
    push(KGnt, 32'd1, 32'h0);
    push(KWr, ACs, 32'h1);
    c1_req = 1'b0;
    wait_for("c1 session close", 6, 1'b1);
    repeat (3) tick();

    // Second tie goes back to client 0; its req drops during POLL.
    push(KWr, ACs, 32'h0);
    push(KGnt, 32'd0, 32'h1);
    c0_req = 1'b1; c1_req = 1'b1;
    wait_for("c0_gnt rise 2", 0, 1'b1);
    push_byte(32'd0, 8'h96);
    push(KGnt, 32'd0, 32'h0);
    push(KWr, ACs, 32'h1);
    push(KWr, ACs, 32'h0);
    push(KGnt, 32'd1, 32'h1);
    c0_tx = 8'h96; c0_stb = 1'b1; tick(); c0_stb = 1'b0;
    wait_for("c0 poll 2", 4, 1'b1);
    c0_req = 1'b0;
    wait_for("c1_gnt rise 2", 1, 1'b1);

    // Reset in the middle of the DATA write.
    push(KGnt, 32'd1, 32'h0);
    c1_tx = 8'h77; c1_stb = 1'b1; tick(); c1_stb = 1'b0;
    wait_for("c1 data write", 5, 1'b1);
    reset_n = 1'b0;
    #1;
    check("async reset m_cyc_o", {31'h0, bus.m_cyc_o}, 32'h0);
    check("async reset m_stb_o", {31'h0, bus.m_stb_o}, 32'h0);
    check("async reset c1_gnt", {31'h0, c1_gnt}, 32'h0);
    push(KWr, ADiv, 32'h3);
    push(KWr, ACs, 32'h1);
    push(KWr, ACs, 32'h0);
    push(KGnt, 32'd1, 32'h1);
    repeat (2) tick();
    reset_n = 1'b1;
    wait_for("c1_gnt after reset", 1, 1'b1);
    push(KGnt, 32'd1, 32'h0);
    push(KWr, ACs, 32'h1);
    c1_req = 1'b0;
    wait_for("final close", 6, 1'b1);
    repeat (5) tick();
    check("pending events", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want earlier finish");
    $fatal(1);
  end

endmodule

// File: doc/spi_xfer_arb.md
# spi_xfer_arb

Two-client transfer controller and arbiter for the `wb_spi` byte engine. It acts as a Wishbone master on the `wb_spi` register window and runs the whole transfer sequence for each byte: initialise the divisor, drive chip select, write the data, poll the run bit, read the result. Two byte-level clients share the one SPI port. Sessions are granted round-robin, and chip select stays asserted for the whole of each session.

## Interface
- `BASE_ADR`, default 32'h0000_0000: byte base address of the `wb_spi` register window.
- `DIVISOR`, default 8'h03: SCK prescaler divisor, written once after reset.
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: one clock; reset is asynchronous and active-low.
- `c0_req` / `c1_req`, in, 1: session request. Held high for the whole session; dropped to end it.
- `c0_gnt` / `c1_gnt`, out, 1: session granted, chip select asserted.
- `c0_stb` / `c1_stb`, in, 1: one-cycle byte strobe.
- `c0_tx` / `c1_tx`, in, 8: byte to send, valid with the strobe.
- `c0_rx` / `c1_rx`, out, 8: received byte, valid from `done` until the next `done`.
- `c0_done` / `c1_done`, out, 1: one-cycle pulse marking byte complete.
- `m_adr_o`, out, 32: Wishbone address.
- `m_dat_o`, out, 32: Wishbone write data.
- `m_dat_i`, in, 32: Wishbone read data.
- `m_sel_o`, out, 4: byte select, constant 4'hF.
- `m_cyc_o` / `m_stb_o` / `m_we_o`, out, 1: Wishbone cycle, strobe and write enable.
- `m_ack_i`, in, 1: Wishbone acknowledge.

## Operation
- Register offsets from `BASE_ADR`: DATA +0x00, STATUS +0x04 (bit 0 = run), CS +0x08, DIV +0x10.
- Chip select is active-low:
  - CS write of 0 selects the device.
  - CS write of 1 deselects it.
- Wishbone access protocol:
  - `cyc`, `stb`, `adr`, `we` and `dat` are held until `m_ack_i` is sampled high.
  - On the ack cycle the FSM advances and `cyc` and `stb` deassert.
  - At least one idle cycle follows between accesses.
- FSM states and transitions:
  - INIT_DIV: write `DIVISOR` to DIV.
  - INIT_CS: write 1 to CS.
  - IDLE: waits for a request.
  - CS_ON: write 0 to CS, then assert `gnt` of the owner.
  - WAIT_BYTE: waits for a strobe or the end of the session.
  - WR_DATA: write the captured tx byte to DATA.
  - POLL: read STATUS.
  - RD_DATA: read DATA.
  - CS_OFF: write 1 to CS.
- Arbitration (in IDLE, either `req` high → CS_ON):
  - Owner is the requester if only one requests.
  - If both request, owner is the client not granted last.
  - The last-grant pointer resets to 1, so client 0 wins the first tie.
- In WAIT_BYTE:
  - The owner's `stb` high → capture the owner's `tx` → WR_DATA.
  - Owner `req` low with no `stb` → `gnt` deasserts next cycle → CS_OFF → IDLE.
  - If `stb` and `req` low occur in the same cycle, the byte is performed first.
- POLL:
  - `m_dat_i[0]` = 1 → one idle cycle, then POLL again.
  - `m_dat_i[0]` = 0 → RD_DATA.
- RD_DATA ack:
  - Owner's `rx` is loaded with `m_dat_i[7:0]` and the owner's `done` pulses.
  - FSM enters WAIT_BYTE on the same edge, so a strobe coincident with `done` is accepted.
- Strobes that are ignored and never queued:
  - a strobe outside WAIT_BYTE;
  - a strobe from the non-owner.
- A `req` drop during a byte does not abort it: `done` still pulses, then the session closes.
- The non-owner's `req` is not serviced until the owner's CS_OFF write is acked. There is no preemption.

## Timing
- Reset values:
  - All `m_*` outputs 0, except `m_sel_o` = 4'hF.
  - `gnt`, `done` and `rx` 0.
  - FSM in INIT_DIV.
- Reset asserted mid-transfer:
  - `m_cyc_o` and `m_stb_o` drop asynchronously.
  - After release, INIT_DIV and INIT_CS rerun before any grant.
- No client can be granted before the INIT_CS ack.
- Grant latency from a `req` rising in IDLE:
  - The CS_ON access starts the next cycle.
  - `gnt` rises the cycle after the CS_ON ack.
- Byte latency: strobe → WR_DATA access → N polls → RD_DATA access → `done` on the RD_DATA ack edge.
  - N ≥ 1; it is the SCK shift time divided by the poll period.
- Each `done` pulse is exactly one cycle long.
- `gnt` stays stable throughout a session.
- At most one access is outstanding at a time.

## Test plan
- Reset, then release with a slave that acks one cycle after `stb`:
  - writes are DIV = 0x03, then CS = 1;
  - no `gnt` appears before the CS ack.
- `c0_req` high, `c0_stb` with `c0_tx` = 0xA5, slave MISO loopback:
  - CS = 0 written before `c0_gnt`;
  - DATA write of 0xA5;
  - STATUS polls until run = 0;
  - `c0_rx` = 0xA5 with a one-cycle `c0_done`.
- Both `req` raised in the same cycle from reset:
  - client 0 is granted first;
  - after its session ends with a CS = 1 write, client 1 is granted;
  - the next tie goes to client 0.
- `c1_stb` pulsed while client 0 owns the port, and `c0_stb` pulsed during POLL:
  - neither strobe produces a DATA write or a `done`.
- `c0_req` dropped during POLL:
  - the byte completes and `c0_done` pulses;
  - then the CS = 1 write;
  - `c0_gnt` is low before the CS_OFF ack.
- `reset_n` pulsed low during WR_DATA:
  - `m_cyc_o` drops immediately;
  - after release, the init sequence repeats and the pending session is re-arbitrated from IDLE.
